// File: rtl/uart_link_top.sv
`default_nettype none
// ============================================================================
// Module   : uart_link_top
// Summary  : TX FIFO + UART transmitter + receiver with runtime loopback.
//            Parity bit and checker are built only when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_link_top #(
  parameter int CLK_CY_PER_BIT = 87,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_Tx_Dv,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Serial,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Loopback,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Dv,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Parity_Err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_CY_PER_BIT * STOP_BITS + 1);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] c_bit_last   = CW'(CLK_CY_PER_BIT - 1);
  localparam logic [CW-1:0] c_stop_last  = CW'(CLK_CY_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] c_half       = CW'(CLK_CY_PER_BIT / 2);
  localparam logic [CW-1:0] c_rx_preload = CW'(2);
  localparam logic [IW-1:0] c_idx_last   = IW'(DATA_BITS - 1);
  localparam logic          c_par_odd    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr, r_rd_ptr;
  logic                 w_full, w_empty, w_push, w_pop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = i_Tx_Dv && !w_full;
  assign o_Tx_Ready = !w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_Tx_Byte;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------- Transmitter ----------------
  state_t               r_tx_state, w_tx_next;
  logic [CW-1:0]        r_tx_cnt;
  logic [IW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_done, w_tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  assign w_tx_bit_end = (r_tx_cnt == c_bit_last);
  assign o_Tx_Active  = (r_tx_state != S_IDLE);
  assign o_Tx_Done    = r_tx_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tx_state <= S_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next   = r_tx_state;
    w_pop       = 1'b0;
    o_Tx_Serial = 1'b1;
    case (r_tx_state)
      S_IDLE: if (!w_empty) begin
        w_pop     = 1'b1;
        w_tx_next = S_START;
      end
      S_START: begin
        o_Tx_Serial = 1'b0;
        if (w_tx_bit_end) w_tx_next = S_DATA;
      end
      S_DATA: begin
        o_Tx_Serial = r_tx_shift[0];
`ifdef UART_PARITY_EN
        if (w_tx_bit_end && r_tx_idx == c_idx_last) w_tx_next = S_PARITY;
      end
      S_PARITY: begin
        o_Tx_Serial = r_tx_par;
        if (w_tx_bit_end) w_tx_next = S_STOP;
`else
        if (w_tx_bit_end && r_tx_idx == c_idx_last) w_tx_next = S_STOP;
`endif
      end
      S_STOP: if (r_tx_cnt == c_stop_last) w_tx_next = S_IDLE;
      default: w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_done  <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_done <= (r_tx_state == S_STOP) && (r_tx_cnt == c_stop_last);
      if (r_tx_state == S_IDLE || w_tx_next != r_tx_state ||
          (r_tx_state == S_DATA && w_tx_bit_end))
        r_tx_cnt <= '0;
      else
        r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_pop) begin
        r_tx_shift <= r_mem[r_rd_ptr[AW-1:0]];
        r_tx_idx   <= '0;
`ifdef UART_PARITY_EN
        r_tx_par   <= (^r_mem[r_rd_ptr[AW-1:0]]) ^ c_par_odd;
`endif
      end else if (r_tx_state == S_DATA && w_tx_bit_end) begin
        r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
        r_tx_idx   <= r_tx_idx + 1'b1;
      end
    end
  end

  // ---------------- Receiver ----------------
  state_t               r_rx_state, w_rx_next;
  logic                 w_rx_in, r_rx_sync1, r_rx_sync2, w_rx_bit_end;
  logic [CW-1:0]        r_rx_cnt;
  logic [IW-1:0]        r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift, r_rx_byte;
  logic                 r_rx_dv, r_rx_ferr;
`ifdef UART_PARITY_EN
  logic                 r_rx_par_bit, r_rx_perr;
`endif

  assign w_rx_in        = i_Loopback ? o_Tx_Serial : i_Rx_Serial;
  assign w_rx_bit_end   = (r_rx_cnt == c_bit_last);
  assign o_Rx_Byte      = r_rx_byte;
  assign o_Rx_Dv        = r_rx_dv;
  assign o_Rx_Frame_Err = r_rx_ferr;
`ifdef UART_PARITY_EN
  assign o_Rx_Parity_Err = r_rx_perr;
`else
  // PARITY_ODD has no meaning without a parity bit
  assign o_Rx_Parity_Err = c_par_odd & 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_state <= S_IDLE;
    end else begin
      r_rx_sync1 <= w_rx_in;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (!r_rx_sync2) w_rx_next = S_START;
      S_START: if (r_rx_cnt == c_half) w_rx_next = r_rx_sync2 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (w_rx_bit_end && r_rx_idx == c_idx_last) w_rx_next = S_PARITY;
      S_PARITY: if (w_rx_bit_end) w_rx_next = S_STOP;
`else
      S_DATA:   if (w_rx_bit_end && r_rx_idx == c_idx_last) w_rx_next = S_STOP;
`endif
      S_STOP:  if (w_rx_bit_end) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  // Count enters START at 2 so the mid-bit point absorbs the synchroniser delay
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_dv    <= 1'b0;
      r_rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par_bit <= 1'b0;
      r_rx_perr    <= 1'b0;
`endif
    end else begin
      r_rx_dv   <= 1'b0;
      r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_perr <= 1'b0;
      if (r_rx_state == S_PARITY && w_rx_bit_end) r_rx_par_bit <= r_rx_sync2;
`endif
      if (r_rx_state == S_IDLE) begin
        r_rx_cnt <= c_rx_preload;
        r_rx_idx <= '0;
      end else if (w_rx_next != r_rx_state || (r_rx_state == S_DATA && w_rx_bit_end)) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
      if (r_rx_state == S_DATA && w_rx_bit_end) begin
        r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_BITS-1:1]};
        r_rx_idx   <= r_rx_idx + 1'b1;
      end
      if (r_rx_state == S_STOP && w_rx_bit_end) begin
        r_rx_byte <= r_rx_shift;
        r_rx_dv   <= 1'b1;
        r_rx_ferr <= !r_rx_sync2;
`ifdef UART_PARITY_EN
        r_rx_perr <= ((^r_rx_shift) ^ c_par_odd) != r_rx_par_bit;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_link_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_link_top
// Summary  : Randomized self-checking bench; expectations come from frame-level
//            arithmetic and a simple FIFO/queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_link_top;
  localparam int CPB   = 8;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME  = (1 + DB + P + SB) * CPB;
  localparam int RX_LAT = 2 + CPB / 2 + (DB + P + 1) * CPB;

  logic       clk = 1'b0, rst = 1'b1;
  logic       i_Tx_Dv = 1'b0, i_Rx_Serial = 1'b1, i_Loopback = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Ready, o_Tx_Active, o_Tx_Done, o_Tx_Serial;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Dv, o_Rx_Frame_Err, o_Rx_Parity_Err;

  int n_checks = 0, n_fails = 0, cyc = 0;

  typedef struct { logic [7:0] data; logic ferr; logic perr; int cyc; } rx_t;
  rx_t rx_q[$];
  int  done_q[$];
  rx_t mon_e;

  uart_link_top #(.CLK_CY_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB),
                  .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_Tx_Dv(i_Tx_Dv), .i_Tx_Byte(i_Tx_Byte),
    .o_Tx_Ready(o_Tx_Ready), .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done),
    .o_Tx_Serial(o_Tx_Serial), .i_Rx_Serial(i_Rx_Serial), .i_Loopback(i_Loopback),
    .o_Rx_Byte(o_Rx_Byte), .o_Rx_Dv(o_Rx_Dv), .o_Rx_Frame_Err(o_Rx_Frame_Err),
    .o_Rx_Parity_Err(o_Rx_Parity_Err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every receive pulse and transmit-done pulse with its edge number
  always @(negedge clk) begin
    if (o_Rx_Dv) begin
      mon_e.data = o_Rx_Byte; mon_e.ferr = o_Rx_Frame_Err;
      mon_e.perr = o_Rx_Parity_Err; mon_e.cyc = cyc;
      rx_q.push_back(mon_e);
    end
    if (o_Tx_Done) done_q.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic even_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic write_byte(input logic [7:0] b, output int n);
    @(posedge clk); #1;
    i_Tx_Dv = 1'b1; i_Tx_Byte = b; n = cyc + 1;
    @(posedge clk); #1;
    i_Tx_Dv = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    int k = 0;
    while (rx_q.size() < n && k < limit) begin @(negedge clk); k++; end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_done(input int n, input int limit, output bit ok);
    int k = 0;
    while (done_q.size() < n && k < limit) begin @(negedge clk); k++; end
    ok = (done_q.size() >= n);
  endtask

  // Drives a whole frame on i_Rx_Serial; e0 is the edge after which the line fell
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            output int e0);
    @(posedge clk); #1;
    i_Rx_Serial = 1'b0; e0 = cyc;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < DB; i++) begin
      i_Rx_Serial = d[i];
      repeat (CPB) @(posedge clk); #1;
    end
    if (P == 1) begin
      i_Rx_Serial = pbit;
      repeat (CPB) @(posedge clk); #1;
    end
    i_Rx_Serial = sbit;
    repeat (CPB) @(posedge clk); #1;
    i_Rx_Serial = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_Tx_Serial !== 1'b1) begin n_fails++; $display("FAIL reset_tx_serial: got %b want 1", o_Tx_Serial); end
    n_checks++; if (o_Tx_Ready !== 1'b1) begin n_fails++; $display("FAIL reset_tx_ready: got %b want 1", o_Tx_Ready); end
    n_checks++; if (o_Tx_Active !== 1'b0) begin n_fails++; $display("FAIL reset_tx_active: got %b want 0", o_Tx_Active); end
    n_checks++; if (o_Tx_Done !== 1'b0) begin n_fails++; $display("FAIL reset_tx_done: got %b want 0", o_Tx_Done); end
    n_checks++; if (o_Rx_Dv !== 1'b0) begin n_fails++; $display("FAIL reset_rx_dv: got %b want 0", o_Rx_Dv); end
    n_checks++; if (o_Rx_Byte !== 8'h00) begin n_fails++; $display("FAIL reset_rx_byte: got %h want 00", o_Rx_Byte); end
    n_checks++; if ({o_Rx_Frame_Err, o_Rx_Parity_Err} !== 2'b00) begin n_fails++; $display("FAIL reset_rx_err: got %b want 00", {o_Rx_Frame_Err, o_Rx_Parity_Err}); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_loopback_single(input logic [7:0] b);
    int n; bit ok;
    i_Loopback = 1'b1;
    rx_q.delete(); done_q.delete();
    write_byte(b, n);
    @(negedge clk);
    n_checks++; if (o_Tx_Serial !== 1'b1) begin n_fails++; $display("FAIL lb_latency_hi: got %b want 1", o_Tx_Serial); end
    @(negedge clk);
    n_checks++; if (o_Tx_Serial !== 1'b0) begin n_fails++; $display("FAIL lb_start_bit: got %b want 0", o_Tx_Serial); end
    wait_done(1, FRAME + 50, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL lb_done_timeout: got none want 1 done"); end
    n_checks++; if (rx_q.size() != 1) begin n_fails++; $display("FAIL lb_dv_count: got %0d want 1", rx_q.size()); end
    if (ok && rx_q.size() >= 1) begin
      n_checks++; if (rx_q[0].data !== b) begin n_fails++; $display("FAIL lb_data: got %h want %h", rx_q[0].data, b); end
      n_checks++; if ({rx_q[0].ferr, rx_q[0].perr} !== 2'b00) begin n_fails++; $display("FAIL lb_errs: got %b want 00", {rx_q[0].ferr, rx_q[0].perr}); end
      n_checks++; if (rx_q[0].cyc != n + 1 + RX_LAT) begin n_fails++; $display("FAIL lb_dv_time: got %0d want %0d", rx_q[0].cyc, n + 1 + RX_LAT); end
      n_checks++; if (done_q[0] != n + 1 + FRAME) begin n_fails++; $display("FAIL lb_done_time: got %0d want %0d", done_q[0], n + 1 + FRAME); end
    end
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_fifo_overflow;
    int n, stored; bit ok;
    logic [7:0] exp_q[$];
    i_Loopback = 1'b1;
    rx_q.delete(); done_q.delete();
    exp_q.push_back(8'($urandom));
    write_byte(exp_q[0], n);
    stored = 0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(posedge clk); #1;
      n_checks++; if (o_Tx_Ready !== (stored < DEPTH)) begin n_fails++; $display("FAIL fifo_ready_w%0d: got %b want %b", k, o_Tx_Ready, stored < DEPTH); end
      if (stored < DEPTH) begin exp_q.push_back(8'(k)); stored++; end
      i_Tx_Dv = 1'b1; i_Tx_Byte = 8'(k);
    end
    @(posedge clk); #1;
    i_Tx_Dv = 1'b0;
    n_checks++; if (o_Tx_Ready !== 1'b0) begin n_fails++; $display("FAIL fifo_ready_after: got %b want 0", o_Tx_Ready); end
    n_checks++; if (o_Tx_Active !== 1'b1) begin n_fails++; $display("FAIL fifo_tx_busy: got %b want 1", o_Tx_Active); end
    wait_rx(exp_q.size(), (DEPTH + 2) * (FRAME + 10), ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL fifo_rx_timeout: got %0d want %0d bytes", rx_q.size(), exp_q.size()); end
    repeat (FRAME + 40) @(posedge clk); #1;
    n_checks++; if (rx_q.size() != exp_q.size()) begin n_fails++; $display("FAIL fifo_rx_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[i].data !== exp_q[i]) begin n_fails++; $display("FAIL fifo_order_%0d: got %h want %h", i, rx_q[i].data, exp_q[i]); end
    end
    for (int i = 0; i + 1 < done_q.size(); i++) begin
      n_checks++; if (done_q[i+1] - done_q[i] != FRAME + 1) begin n_fails++; $display("FAIL fifo_gap_%0d: got %0d want %0d", i, done_q[i+1] - done_q[i], FRAME + 1); end
    end
  endtask

  task automatic test_frame_err;
    int e0; bit ok; logic [7:0] d;
    i_Loopback = 1'b0; i_Rx_Serial = 1'b1;
    rx_q.delete();
    send_frame(8'h3C, even_par(8'h3C), 1'b0, e0);
    wait_rx(1, 20, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL ferr_timeout: got none want 1 dv"); end
    if (ok) begin
      n_checks++; if (rx_q[0].data !== 8'h3C) begin n_fails++; $display("FAIL ferr_data: got %h want 3c", rx_q[0].data); end
      n_checks++; if (rx_q[0].ferr !== 1'b1) begin n_fails++; $display("FAIL ferr_flag: got %b want 1", rx_q[0].ferr); end
      n_checks++; if (rx_q[0].perr !== 1'b0) begin n_fails++; $display("FAIL ferr_perr: got %b want 0", rx_q[0].perr); end
      n_checks++; if (rx_q[0].cyc != e0 + RX_LAT) begin n_fails++; $display("FAIL ferr_dv_time: got %0d want %0d", rx_q[0].cyc, e0 + RX_LAT); end
    end
    // A stop bit held low looks like a new start; let that resolve before moving on
    repeat (2 * FRAME) @(posedge clk); #1;
    for (int t = 0; t < 3; t++) begin
      rx_q.delete();
      d = 8'($urandom);
      send_frame(d, even_par(d), 1'b1, e0);
      wait_rx(1, 20, ok);
      n_checks++; if (!ok || rx_q[0].data !== d || rx_q[0].ferr !== 1'b0 || rx_q[0].perr !== 1'b0) begin
        n_fails++; $display("FAIL ext_frame_%0d: got ok=%0d data=%h err=%b%b want %h err=00", t, ok,
                            ok ? rx_q[0].data : 8'h00, ok ? rx_q[0].ferr : 1'b0, ok ? rx_q[0].perr : 1'b0, d);
      end
    end
  endtask

  task automatic test_glitch;
    int e0, len; bit ok;
    i_Loopback = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rx_q.delete();
      len = (g == 0) ? 2 : int'($urandom_range(1, 3));
      @(posedge clk); #1;
      i_Rx_Serial = 1'b0;
      repeat (len) @(posedge clk); #1;
      i_Rx_Serial = 1'b1;
      repeat (FRAME + 20) @(posedge clk); #1;
      n_checks++; if (rx_q.size() != 0) begin n_fails++; $display("FAIL glitch_%0d_len%0d: got %0d dv want 0", g, len, rx_q.size()); end
    end
    send_frame(8'h7E, even_par(8'h7E), 1'b1, e0);
    wait_rx(1, 20, ok);
    n_checks++; if (!ok || rx_q[0].data !== 8'h7E || rx_q[0].ferr !== 1'b0) begin
      n_fails++; $display("FAIL glitch_recover: got ok=%0d data=%h want 7e", ok, ok ? rx_q[0].data : 8'h00);
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int e0; bit ok; logic [7:0] d;
    i_Loopback = 1'b0;
    for (int t = 0; t < 4; t++) begin
      logic pb;
      d  = (t < 2) ? 8'h03 : 8'($urandom);
      pb = (t % 2 == 0) ? ~even_par(d) : even_par(d);
      rx_q.delete();
      send_frame(d, pb, 1'b1, e0);
      wait_rx(1, 20, ok);
      n_checks++; if (!ok || rx_q[0].perr !== (pb != even_par(d)) || rx_q[0].data !== d) begin
        n_fails++; $display("FAIL parity_%0d: got ok=%0d perr=%b data=%h want perr=%b data=%h", t, ok,
                            ok ? rx_q[0].perr : 1'b0, ok ? rx_q[0].data : 8'h00, pb != even_par(d), d);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    int n, n2, target; logic [7:0] b1;
    i_Loopback = 1'b1;
    rx_q.delete(); done_q.delete();
    b1 = 8'($urandom);
    write_byte(b1, n);
    write_byte(8'($urandom), n2);
    target = n + 1 + CPB * 4 + CPB / 2;
    while (cyc < target) begin @(posedge clk); #1; end
    n_checks++; if (o_Tx_Serial !== b1[3]) begin n_fails++; $display("FAIL rst_mid_bit3: got %b want %b", o_Tx_Serial, b1[3]); end
    rst = 1'b1; #1;
    n_checks++; if (o_Tx_Serial !== 1'b1) begin n_fails++; $display("FAIL rst_mid_serial: got %b want 1", o_Tx_Serial); end
    n_checks++; if (o_Tx_Ready !== 1'b1 || o_Tx_Active !== 1'b0) begin n_fails++; $display("FAIL rst_mid_state: got ready=%b active=%b want 1 0", o_Tx_Ready, o_Tx_Active); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (FRAME + 30) @(posedge clk); #1;
    n_checks++; if (done_q.size() != 0 || rx_q.size() != 0) begin n_fails++; $display("FAIL rst_mid_quiet: got done=%0d dv=%0d want 0 0", done_q.size(), rx_q.size()); end
    test_loopback_single(8'h5A);
  endtask

  initial begin
    test_reset;
    test_loopback_single(8'hA5);
    for (int i = 0; i < 3; i++) test_loopback_single(8'($urandom));
    test_fifo_overflow;
    test_frame_err;
    test_glitch;
`ifdef UART_PARITY_EN
    test_parity;
`endif
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_link_top.md
# uart_link_top

Parametrised UART transceiver, the successor to the fixed 8N1 TX/RX pair. It combines a transmit FIFO, a transmitter and a receiver. Frame format is configurable: data bits, optional parity and stop bits. It reports receive errors. A runtime loopback mux routes the TX serial line into the RX path for self-test. It sits between the host-side byte interface and the external serial pins.

## Interface
Parameters:
- CLK_CY_PER_BIT, default 87: clock cycles per bit period; must be ≥ 4.
- DATA_BITS, default 8: data bits per frame, legal range 5–8.
- STOP_BITS, default 1: stop bits transmitted, 1 or 2.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd. Only meaningful with UART_PARITY_EN.
- FIFO_DEPTH, default 4: TX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- i_clk, input, 1: the single clock. All logic is on its rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_Tx_Dv, input, 1: write strobe for i_Tx_Byte.
- i_Tx_Byte, input, DATA_BITS: byte to transmit.
- o_Tx_Ready, output, 1: high when the FIFO is not full.
- o_Tx_Active, output, 1: high while a frame is on the line.
- o_Tx_Done, output, 1: one-cycle pulse at the end of the last stop bit.
- o_Tx_Serial, output, 1: serial out; idles high.
- i_Rx_Serial, input, 1: external serial in.
- i_Loopback, input, 1: when 1, the RX path uses o_Tx_Serial and i_Rx_Serial is ignored.
- o_Rx_Byte, output, DATA_BITS: last received data.
- o_Rx_Dv, output, 1: one-cycle pulse when a frame completes.
- o_Rx_Frame_Err, output, 1: valid with o_Rx_Dv; sampled stop bit was 0.
- o_Rx_Parity_Err, output, 1: valid with o_Rx_Dv; parity mismatch. Tied 0 without UART_PARITY_EN.

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Ready=1, all other outputs 0. FIFO is emptied and both state machines go to IDLE.
- Reset mid-frame aborts the frame immediately: the line returns high and no Done or Dv pulse is produced.
- FIFO write: a byte is accepted on a rising edge where i_Tx_Dv=1 and o_Tx_Ready=1.
- A write while full is dropped silently; the FIFO contents are unchanged.
- A simultaneous write and pop when full is legal, because o_Tx_Ready reflects pre-edge state.
- TX state machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE with the FIFO non-empty: pop the head and enter START.
  - Each state holds CLK_CY_PER_BIT cycles per bit.
  - DATA sends bits LSB first; the bit index counts 0 to DATA_BITS−1.
  - STOP lasts STOP_BITS bit periods.
  - o_Tx_Active=1 in every state except IDLE.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, TX goes through IDLE for one cycle and then starts the next frame.
- RX state machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - The RX input first passes through a 2-flop synchroniser.
  - IDLE leaves on a synchronised 0.
  - START rechecks the line at count CLK_CY_PER_BIT/2 (integer division). If the line is 1, it is a glitch: return to IDLE with no output.
  - After that, each bit is sampled every CLK_CY_PER_BIT cycles, at mid-bit.
  - Only the first stop bit is checked.
- Completion: at the stop-bit sample, o_Rx_Byte is updated, o_Rx_Dv pulses, the error flags are valid in the same cycle, and RX goes to IDLE.
  - A frame with a framing error still produces Dv and still updates o_Rx_Byte.
- Parity is the XOR of the data bits, inverted when PARITY_ODD=1.
- Switching i_Loopback mid-frame is allowed. The resulting frame content is undefined, but both state machines recover within one frame time.

## Timing
- TX latency: a write at edge N into an empty FIFO with TX idle makes o_Tx_Serial go low after edge N+1.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × CLK_CY_PER_BIT cycles, where P=1 with parity and 0 without.
- o_Tx_Done is asserted in the cycle after the last stop-bit cycle; TX is in IDLE during that cycle.
- o_Tx_Ready deasserts the cycle after the FIFO_DEPTH-th un-popped write.
- RX: o_Rx_Dv is asserted (2 + CLK_CY_PER_BIT/2 + (DATA_BITS+P+1)×CLK_CY_PER_BIT) cycles after the falling edge on the selected RX input. The 2 cycles are synchroniser latency.
- In loopback, o_Rx_Dv for a frame precedes that frame's o_Tx_Done.

## Configuration
- UART_PARITY_EN defined: the PARITY state is present in TX and RX, adding one bit per frame. The parity bit is generated per PARITY_ODD and checked into o_Rx_Parity_Err.
- UART_PARITY_EN undefined: there is no PARITY state and no parity logic. o_Rx_Parity_Err is tied to 0 and PARITY_ODD is ignored.

## Test plan
All scenarios use CLK_CY_PER_BIT=8, DATA_BITS=8, STOP_BITS=1 and FIFO_DEPTH=4 unless stated otherwise.
- Loopback single byte: i_Loopback=1, write 0xA5 → o_Rx_Dv pulses once with o_Rx_Byte=0xA5 and both error flags 0. o_Tx_Done follows, 80 cycles after the start bit, or 88 with parity.
- FIFO fill/overflow: write 0x01…0x05 on consecutive cycles with TX busy → o_Tx_Ready=0 after the 4th write, 0x05 is dropped, and RX receives 0x01–0x04 in order with no IDLE gap beyond 1 cycle.
- Framing error: drive i_Rx_Serial with the frame for 0x3C but stop bit=0 → o_Rx_Dv=1, o_Rx_Byte=0x3C, o_Rx_Frame_Err=1.
- Start glitch: pulse i_Rx_Serial low for 2 cycles → no o_Rx_Dv. A valid 0x7E frame sent afterwards is received correctly.
- Parity (UART_PARITY_EN, PARITY_ODD=0): send 0x03 with parity bit 1 → o_Rx_Parity_Err=1. Send it with parity bit 0 → o_Rx_Parity_Err=0.
- Reset mid-frame: assert i_rst during TX bit 3 → o_Tx_Serial=1 immediately, FIFO empty, no o_Tx_Done. After release, a write of 0x5A is transmitted and received correctly.
